fetch_unit: RTL
===============

Name: fetch_unit

Overview:
- Instruction fetch stage of the Gigatron-style datapath; the producer side of the control unit's IR input.
- Holds the 16-bit program counter and drives the program ROM address.
- Registers the fetched ROM word into IR (opcode byte) and D (operand byte), which feed the control unit and the D->BUS driver.
- Applies the PL/PH branch strobes from the control unit with the architectural one-instruction delay slot.

Parameters:
- PC_W, 16, program counter / ROM address width
- RESET_PC, 16'h0000, PC value loaded on reset
- NOP_OP, 8'h02, opcode placed in IR on reset (ld ac)

Ports:
- CLK  input  1  system clock; all state updates on rising edge
- RST  input  1  synchronous reset, active-high
- HOLD  input  1  freeze fetch: PC, IR, D and FETCH_PC keep their values
- PL  input  1  load PC low byte from BUS (near branch), from control unit
- PH  input  1  load full PC from {Y, BUS} (far jump), from control unit
- BUS  input  8  data bus value, the branch target low byte
- Y  input  8  Y register, the far-jump target high byte
- ROM_DATA  input  16  ROM word at ROM_ADDR; [15:8] opcode, [7:0] operand; combinational ROM
- ROM_ADDR  output  PC_W  current PC, driven directly from the PC register
- IR  output  8  registered opcode to the control unit
- D  output  8  registered operand byte
- FETCH_PC  output  PC_W  address the current IR/D were fetched from (debug/trace)
- HALTED  output  1  breakpoint halt flag; present only with the feature enabled

Behaviour:
- Reset is synchronous and active-high. RST=1 at a rising edge sets PC=RESET_PC, IR=NOP_OP, D=8'h00, FETCH_PC=RESET_PC and HALTED=0. RST has priority over HOLD, PL, PH and the breakpoint.
- Reset mid-operation discards any in-flight branch. The first instruction after reset is the one at RESET_PC, visible in IR one cycle after RST deasserts.
- Normal cycle (RST=0, HOLD=0):
  - IR<=ROM_DATA[15:8]; D<=ROM_DATA[7:0]; FETCH_PC<=PC.
  - PC next: if PH then {Y,BUS}; else if PL then {PC[15:8],BUS}; else PC+1.
  - PH has priority over PL when both are asserted.
- Delay slot: PL/PH are decoded from the instruction currently in IR. The word fetched in the same cycle (at PC) is committed to IR and executes. The branch target enters IR on the following cycle. Latency: 2 cycles from a branch being in IR to its target being in IR.
- Back-to-back branches are legal. A branch in the delay slot redirects again using that cycle's BUS/Y.
- Wrap-around: PC+1 from 16'hFFFF gives 16'h0000 (mod 2^PC_W). A near branch keeps the high byte even when the low byte wraps: PC=16'h12FF with PL and BUS=8'h00 gives 16'h1200.
- HOLD=1: all registers keep their values, PL/PH are ignored, and ROM_ADDR is stable. Releasing HOLD resumes with the same IR, so the control unit re-presents the same branch decision.
- ROM_ADDR, IR, D and FETCH_PC have no combinational path from inputs. ROM_ADDR is the PC register output.

Optional Feature:
- Macro: FETCH_BREAKPOINT_EN.
- With the macro defined:
  - Extra input BP_ADDR (PC_W) and extra input BP_ARM (1) are added, plus output HALTED.
  - When BP_ARM=1, HALTED=0 and PC==BP_ADDR at a non-held edge, the fetch completes normally (the word at BP_ADDR enters IR) and HALTED<=1.
  - While HALTED=1, the unit behaves as HOLD=1.
  - HALTED clears only on RST, or when BP_ARM=0 at an edge; fetch resumes on the next edge after that.
- Without the macro: no BP_ADDR/BP_ARM/HALTED ports, no comparator logic, and behaviour is identical to the feature with BP_ARM=0.

Decomposition:
- Shared package gigatron_pkg holds:
  - PC_W and the byte width constant;
  - the NOP_OP value;
  - the ROM word field positions (OPC_MSB/LSB, OPR_MSB/LSB).
- One sub-module, fetch_pc: the PC register with increment, near-load and far-load muxing, HOLD enable and reset. It exposes next_pc and pc.
- fetch_unit instantiates fetch_pc and adds the IR/D/FETCH_PC registers and the optional breakpoint logic.

Test Plan:
- Reset: RST=1 for 2 cycles with arbitrary ROM_DATA -> ROM_ADDR=0000, IR=02, D=00, FETCH_PC=0000. After release, IR/D equal ROM[0000] one cycle later.
- Linear fetch with ROM[n]={n[7:0],~n[7:0]}, 5 cycles -> ROM_ADDR 0000..0004 and IR/D trail by one cycle; FETCH_PC matches the address of each IR.
- Near branch: PL=1, BUS=40 while PC=0105 -> ROM[0105] enters IR (delay slot), then PC=0140, then IR=ROM[0140].
- Far jump plus priority: PH=1 and PL=1 with Y=20, BUS=10 -> next PC=2010. Also run PL in the delay slot with BUS=55 -> PC=2055.
- Wrap and HOLD:
  - PC=FFFF, no branch -> PC=0000.
  - HOLD=1 for 3 cycles with PL=1 -> PC, IR and D unchanged.
  - Release HOLD -> branch applies once.
- FETCH_BREAKPOINT_EN:
  - BP_ARM=1, BP_ADDR=0003 -> HALTED=1 after the fetch at 0003; IR=ROM[0003] and PC=0004 are frozen.
  - BP_ARM=0 -> HALTED=0 at the next edge; PC=0005 on the following edge.

Source files
------------

// File: rtl/gigatron_pkg.sv
// Shared constants for the Gigatron-style datapath: widths, reset opcode and
// the split of a 16-bit ROM word into opcode and operand bytes.
package gigatron_pkg;

    localparam int PC_W   = 16;
    localparam int BYTE_W = 8;
    localparam int ROM_W  = 16;

    localparam logic [BYTE_W-1:0] NOP_OP = 8'h02;

    localparam int OPC_MSB = 15;
    localparam int OPC_LSB = 8;
    localparam int OPR_MSB = 7;
    localparam int OPR_LSB = 0;

endpackage

// File: rtl/fetch_pc.sv
// Program counter register: increment, near load of the low byte, far load of
// the whole PC, freeze on hold and synchronous reset.
module fetch_pc #(
    parameter int              PC_W     = gigatron_pkg::PC_W,
    parameter logic [PC_W-1:0] RESET_PC = {PC_W{1'b0}}
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            hold,
    input  logic                            pl,
    input  logic                            ph,
    input  logic [gigatron_pkg::BYTE_W-1:0] bus,
    input  logic [gigatron_pkg::BYTE_W-1:0] y,
    output logic [PC_W-1:0]                 next_pc,
    output logic [PC_W-1:0]                 pc
);
    import gigatron_pkg::*;

    logic [PC_W-1:0] pc_r;
    logic [PC_W-1:0] next_pc_s;

    // Branch target selection; a far jump wins over a near branch.
    always_comb begin
        next_pc_s = pc_r + {{(PC_W-1){1'b0}}, 1'b1};
        if (ph) begin
            next_pc_s = PC_W'({y, bus});
        end else if (pl) begin
            next_pc_s = {pc_r[PC_W-1:BYTE_W], bus};
        end else begin
            next_pc_s = pc_r + {{(PC_W-1){1'b0}}, 1'b1};
        end
    end

    // PC register with hold enable.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_r <= RESET_PC;
        end else if (hold) begin
            pc_r <= pc_r;
        end else begin
            pc_r <= next_pc_s;
        end
    end

    assign next_pc = next_pc_s;
    assign pc      = pc_r;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC, IR/D/FETCH_PC registers and branch strobes with
// a one-instruction delay slot. Optional breakpoint halt under FETCH_BREAKPOINT_EN.
module fetch_unit #(
    parameter int              PC_W     = gigatron_pkg::PC_W,
    parameter logic [PC_W-1:0] RESET_PC = {PC_W{1'b0}},
    parameter logic [7:0]      NOP_OP   = gigatron_pkg::NOP_OP
) (
    input  logic                           CLK,
    input  logic                           RST,
    input  logic                           HOLD,
    input  logic                           PL,
    input  logic                           PH,
    input  logic [gigatron_pkg::BYTE_W-1:0] BUS,
    input  logic [gigatron_pkg::BYTE_W-1:0] Y,
    input  logic [gigatron_pkg::ROM_W-1:0]  ROM_DATA,
`ifdef FETCH_BREAKPOINT_EN
    input  logic [PC_W-1:0]                BP_ADDR,
    input  logic                           BP_ARM,
    output logic                           HALTED,
`endif
    output logic [PC_W-1:0]                ROM_ADDR,
    output logic [gigatron_pkg::BYTE_W-1:0] IR,
    output logic [gigatron_pkg::BYTE_W-1:0] D,
    output logic [PC_W-1:0]                FETCH_PC
);
    import gigatron_pkg::*;

    logic              hold_s;
    logic [PC_W-1:0]   pc_s;
    logic [PC_W-1:0]   next_pc_unused_s;
    logic [BYTE_W-1:0] ir_r;
    logic [BYTE_W-1:0] d_r;
    logic [PC_W-1:0]   fetch_pc_r;

`ifdef FETCH_BREAKPOINT_EN
    logic halted_r;

    // Halt latches after the fetch at BP_ADDR and stays set until disarmed.
    always_ff @(posedge CLK) begin
        if (RST) begin
            halted_r <= 1'b0;
        end else if (!BP_ARM) begin
            halted_r <= 1'b0;
        end else if (!halted_r && !HOLD && (pc_s == BP_ADDR)) begin
            halted_r <= 1'b1;
        end else begin
            halted_r <= halted_r;
        end
    end

    assign hold_s = HOLD | halted_r;
    assign HALTED = halted_r;
`else
    assign hold_s = HOLD;
`endif

    fetch_pc #(
        .PC_W     (PC_W),
        .RESET_PC (RESET_PC)
    ) u_fetch_pc (
        .clk     (CLK),
        .rst     (RST),
        .hold    (hold_s),
        .pl      (PL),
        .ph      (PH),
        .bus     (BUS),
        .y       (Y),
        .next_pc (next_pc_unused_s),
        .pc      (pc_s)
    );

    // Capture the word at the current PC together with the address it came from.
    always_ff @(posedge CLK) begin
        if (RST) begin
            ir_r       <= NOP_OP;
            d_r        <= 8'h00;
            fetch_pc_r <= RESET_PC;
        end else if (hold_s) begin
            ir_r       <= ir_r;
            d_r        <= d_r;
            fetch_pc_r <= fetch_pc_r;
        end else begin
            ir_r       <= ROM_DATA[OPC_MSB:OPC_LSB];
            d_r        <= ROM_DATA[OPR_MSB:OPR_LSB];
            fetch_pc_r <= pc_s;
        end
    end

    assign ROM_ADDR = pc_s;
    assign IR       = ir_r;
    assign D        = d_r;
    assign FETCH_PC = fetch_pc_r;

endmodule
